mar_burst: RTL

Parametrised memory address register with auto-increment and a burst address generator. It replaces the fixed 4-bit load-only MAR between the CPU address source and the memory address bus (ABUS). It holds the current address, loads it from the internal bus, and steps it by one on request. It can also issue a run of consecutive addresses to memory under a valid/ready handshake.

---
 rtl/mar_pkg.sv | 13 +
 rtl/burst_counter.sv | 32 +++
 rtl/mar_burst.sv | 91 +++++++++
 3 files changed

// File: rtl/mar_pkg.sv
// Shared types and defaults for the memory address register with burst generator.
// Imported by mar_burst and burst_counter.
package mar_pkg;

    localparam int AW_DEF   = 4;
    localparam int LENW_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

endpackage

// File: rtl/burst_counter.sv
// Loadable down-counter holding the beats left in a burst.
// The last flag marks the beat whose acceptance ends the burst.
module burst_counter
    import mar_pkg::*;
#(
    parameter int LENW = LENW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [LENW-1:0] load_val,
    input  logic            dec,
    input  logic            clear,
    output logic            last
);

    logic [LENW-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (dec && count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign last = (count == LENW'(1));

endmodule

// File: rtl/mar_burst.sv
// Memory address register: load, single-step increment, and a valid/ready burst
// address generator that walks consecutive addresses from the current value.
module mar_burst
    import mar_pkg::*;
#(
    parameter int AW   = AW_DEF,
    parameter int LENW = LENW_DEF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic [AW-1:0]   addr_in,
    input  logic            inc,
    input  logic            burst_start,
    input  logic [LENW-1:0] burst_len,
    input  logic            mem_ready,
    output logic [AW-1:0]   abus,
    output logic            abus_valid,
    output logic            busy,
    output logic            burst_done
);

    state_t state;
    logic   start_ok;
    logic   beat_ok;
    logic   last_beat;

    // A zero-length request is dropped entirely; ld outranks burst_start.
    assign start_ok = (state == IDLE) && !ld && burst_start && (burst_len != '0);
    assign beat_ok  = abus_valid && mem_ready && !ld;

    burst_counter #(
        .LENW(LENW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (start_ok),
        .load_val (burst_len),
        .dec      (beat_ok),
        .clear    (ld),
        .last     (last_beat)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            abus       <= '0;
            abus_valid <= 1'b0;
            busy       <= 1'b0;
            burst_done <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (ld) begin
                        abus <= addr_in;
                    end else if (start_ok) begin
                        state      <= BURST;
                        abus_valid <= 1'b1;
                        busy       <= 1'b1;
                    end else if (inc) begin
                        abus <= abus + 1'b1;
                    end
                end
                BURST: begin
                    // ld aborts without a done pulse; inc and burst_start are ignored here.
                    if (ld) begin
                        abus       <= addr_in;
                        state      <= IDLE;
                        abus_valid <= 1'b0;
                        busy       <= 1'b0;
                    end else if (beat_ok) begin
                        abus <= abus + 1'b1;
                        if (last_beat) begin
                            state      <= IDLE;
                            abus_valid <= 1'b0;
                            busy       <= 1'b0;
                            burst_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    abus_valid <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
